// File: rtl/block_memory_pkg.sv
// Shared geometry for the banked memory controller: widths, port count and
// the bank/offset split of an address.
package block_memory_pkg;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int BANK_BITS  = 4;
    localparam int NUM_PORTS  = 4;

    localparam int OFF_W      = ADDR_W - BANK_BITS;
    localparam int BANK_LSB   = OFF_W;
    localparam int BANK_MSB   = ADDR_W - 1;
    localparam int NUM_BANKS  = 1 << BANK_BITS;
    localparam int BANK_DEPTH = 1 << OFF_W;
endpackage

// File: rtl/block_memory_controller_bank_ram.sv
// One memory bank: synchronous read, single write port, read-first on a
// same-address collision. Contents are never cleared.
module bank_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/block_memory_controller.sv
// Four read and four write ports onto sixteen single-read/single-write banks,
// with fixed-priority per-bank arbitration (port 1 highest).
module block_memory_controller #(
    parameter int ADDR_W    = block_memory_pkg::ADDR_W,
    parameter int DATA_W    = block_memory_pkg::DATA_W,
    parameter int BANK_BITS = block_memory_pkg::BANK_BITS,
    parameter int NUM_PORTS = block_memory_pkg::NUM_PORTS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] rd_addr3,
    input  logic [ADDR_W-1:0] rd_addr4,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [ADDR_W-1:0] wr_addr3,
    input  logic [ADDR_W-1:0] wr_addr4,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic [DATA_W-1:0] wr_data3,
    input  logic [DATA_W-1:0] wr_data4,
    input  logic              wr_enable1,
    input  logic              wr_enable2,
    input  logic              wr_enable3,
    input  logic              wr_enable4,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_data3,
    output logic [DATA_W-1:0] rd_data4,
    output logic              rd_enable1,
    output logic              rd_enable2,
    output logic              rd_enable3,
    output logic              rd_enable4,
    output logic              wr_enable_out1,
    output logic              wr_enable_out2,
    output logic              wr_enable_out3,
    output logic              wr_enable_out4
);
    localparam int OFF_W     = ADDR_W - BANK_BITS;
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0][ADDR_W-1:0]    ra, wa;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    wd;
    logic [NUM_PORTS-1:0]                we;
    logic [NUM_PORTS-1:0][BANK_BITS-1:0] rd_bank, wr_bank;

    assign ra = {rd_addr4, rd_addr3, rd_addr2, rd_addr1};
    assign wa = {wr_addr4, wr_addr3, wr_addr2, wr_addr1};
    assign wd = {wr_data4, wr_data3, wr_data2, wr_data1};
    assign we = {wr_enable4, wr_enable3, wr_enable2, wr_enable1};

    logic [NUM_BANKS-1:0][PW-1:0] rd_sel, wr_sel;
    logic [NUM_BANKS-1:0]         wr_any;
    logic [NUM_PORTS-1:0]         rd_grant, wr_commit;

    // Scanning from the lowest-priority port down lets port 1 overwrite last.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_sel[b] = '0;
            wr_sel[b] = '0;
            wr_any[b] = 1'b0;
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (ra[p][ADDR_W-1:OFF_W] == BANK_BITS'(b))
                    rd_sel[b] = PW'(p);
                if (we[p] && wa[p][ADDR_W-1:OFF_W] == BANK_BITS'(b)) begin
                    wr_sel[b] = PW'(p);
                    wr_any[b] = 1'b1;
                end
            end
        end
    end

    // A read port is served when it matches the winning address of its bank.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_bank[p]   = ra[p][ADDR_W-1:OFF_W];
            wr_bank[p]   = wa[p][ADDR_W-1:OFF_W];
            rd_grant[p]  = (ra[p] == ra[rd_sel[rd_bank[p]]]);
            wr_commit[p] = we[p] && (wr_sel[wr_bank[p]] == PW'(p));
        end
    end

    logic [NUM_BANKS-1:0][OFF_W-1:0]  bank_ra, bank_wa;
    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_wd, bank_dout;
    logic [NUM_BANKS-1:0]             bank_we;

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        assign bank_ra[gb] = ra[rd_sel[gb]][OFF_W-1:0];
        assign bank_wa[gb] = wa[wr_sel[gb]][OFF_W-1:0];
        assign bank_wd[gb] = wd[wr_sel[gb]];
        assign bank_we[gb] = wr_any[gb] & reset;

        bank_ram #(.AW(OFF_W), .DW(DATA_W)) u_ram (
            .clk (clk),
            .we  (bank_we[gb]),
            .wa  (bank_wa[gb]),
            .wd  (bank_wd[gb]),
            .ra  (bank_ra[gb]),
            .rd  (bank_dout[gb])
        );
    end

    logic [NUM_PORTS-1:0]                grant_q, wr_out_q;
    logic [NUM_PORTS-1:0][BANK_BITS-1:0] bank_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    hold_q, rd_q;

    // hold_q keeps the last delivered word so a losing port repeats it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q  <= '0;
            wr_out_q <= '0;
            bank_q   <= '0;
            hold_q   <= '0;
        end else begin
            grant_q  <= rd_grant;
            wr_out_q <= wr_commit;
            bank_q   <= rd_bank;
            for (int p = 0; p < NUM_PORTS; p++)
                if (grant_q[p])
                    hold_q[p] <= bank_dout[bank_q[p]];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            rd_q[p] = grant_q[p] ? bank_dout[bank_q[p]] : hold_q[p];
    end

    assign {rd_data4, rd_data3, rd_data2, rd_data1}                 = rd_q;
    assign {rd_enable4, rd_enable3, rd_enable2, rd_enable1}         = grant_q;
    assign {wr_enable_out4, wr_enable_out3, wr_enable_out2, wr_enable_out1} = wr_out_q;
endmodule

// File: tb/tb_block_memory_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// word-level model of the banked memory.
module tb_block_memory_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] rd_addr1, rd_addr2, rd_addr3, rd_addr4;
    logic [11:0] wr_addr1, wr_addr2, wr_addr3, wr_addr4;
    logic [31:0] wr_data1, wr_data2, wr_data3, wr_data4;
    logic        wr_enable1, wr_enable2, wr_enable3, wr_enable4;
    logic [31:0] rd_data1, rd_data2, rd_data3, rd_data4;
    logic        rd_enable1, rd_enable2, rd_enable3, rd_enable4;
    logic        wr_enable_out1, wr_enable_out2, wr_enable_out3, wr_enable_out4;

    block_memory_controller dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3), .rd_addr4(rd_addr4),
        .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3), .wr_addr4(wr_addr4),
        .wr_data1(wr_data1), .wr_data2(wr_data2), .wr_data3(wr_data3), .wr_data4(wr_data4),
        .wr_enable1(wr_enable1), .wr_enable2(wr_enable2), .wr_enable3(wr_enable3), .wr_enable4(wr_enable4),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3), .rd_data4(rd_data4),
        .rd_enable1(rd_enable1), .rd_enable2(rd_enable2), .rd_enable3(rd_enable3), .rd_enable4(rd_enable4),
        .wr_enable_out1(wr_enable_out1), .wr_enable_out2(wr_enable_out2),
        .wr_enable_out3(wr_enable_out3), .wr_enable_out4(wr_enable_out4)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] ra_d [4];
    logic [11:0] wa_d [4];
    logic [31:0] wd_d [4];
    logic        we_d [4];

    logic [31:0] mem_m [4096];
    bit          mem_v [4096];
    logic [31:0] exp_d [4];
    bit          exp_k [4];
    bit          exp_en [4];
    bit          exp_wo [4];

    logic [31:0] got_d [4];
    logic        got_en [4];
    logic        got_wo [4];
    assign got_d[0] = rd_data1;  assign got_d[1] = rd_data2;
    assign got_d[2] = rd_data3;  assign got_d[3] = rd_data4;
    assign got_en[0] = rd_enable1;  assign got_en[1] = rd_enable2;
    assign got_en[2] = rd_enable3;  assign got_en[3] = rd_enable4;
    assign got_wo[0] = wr_enable_out1;  assign got_wo[1] = wr_enable_out2;
    assign got_wo[2] = wr_enable_out3;  assign got_wo[3] = wr_enable_out4;

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            exp_d[n] = 32'h0; exp_k[n] = 1'b1; exp_en[n] = 1'b0; exp_wo[n] = 1'b0;
        end
    endtask

    // Idle: no writes, each port reading its own otherwise unused bank.
    task automatic clr();
        for (int n = 0; n < 4; n++) begin
            ra_d[n] = 12'hC00 + 12'(n * 256);
            wa_d[n] = 12'h0; wd_d[n] = 32'h0; we_d[n] = 1'b0;
        end
    endtask

    // Drive the staged inputs, predict the next outputs, clock once.
    task automatic step();
        logic [31:0] nd [4];
        bit nk [4], nen [4], nwo [4], taken [16];
        int win;
        rd_addr1 = ra_d[0]; rd_addr2 = ra_d[1]; rd_addr3 = ra_d[2]; rd_addr4 = ra_d[3];
        wr_addr1 = wa_d[0]; wr_addr2 = wa_d[1]; wr_addr3 = wa_d[2]; wr_addr4 = wa_d[3];
        wr_data1 = wd_d[0]; wr_data2 = wd_d[1]; wr_data3 = wd_d[2]; wr_data4 = wd_d[3];
        wr_enable1 = we_d[0]; wr_enable2 = we_d[1]; wr_enable3 = we_d[2]; wr_enable4 = we_d[3];
        for (int b = 0; b < 16; b++) taken[b] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            nd[n] = exp_d[n]; nk[n] = exp_k[n]; nen[n] = 1'b0; nwo[n] = 1'b0;
        end
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                win = n;
                for (int m = 3; m >= 0; m--)
                    if (ra_d[m] / 256 == ra_d[n] / 256) win = m;
                if (ra_d[win] == ra_d[n]) begin
                    nen[n] = 1'b1;
                    nd[n]  = mem_m[ra_d[n]];
                    nk[n]  = mem_v[ra_d[n]];
                end
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                nd[n] = 32'h0; nk[n] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            for (int n = 0; n < 4; n++)
                if (we_d[n] && !taken[wa_d[n] / 256]) begin
                    taken[wa_d[n] / 256] = 1'b1;
                    nwo[n] = 1'b1;
                    mem_m[wa_d[n]] = wd_d[n];
                    mem_v[wa_d[n]] = 1'b1;
                end
        end
        for (int n = 0; n < 4; n++) begin
            exp_d[n] = nd[n]; exp_k[n] = nk[n]; exp_en[n] = nen[n]; exp_wo[n] = nwo[n];
        end
    endtask

    task automatic test_reset();
        clr();
        step();
        step();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (got_d[n] !== 32'h0 || got_en[n] !== 1'b0 || got_wo[n] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs port%0d: got data=%h en=%b wo=%b, expected 0/0/0",
                         n + 1, got_d[n], got_en[n], got_wo[n]);
            end
        end
        reset = 1'b1;
        clr();
        step();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (got_en[n] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_en port%0d: got %b expected 1", n + 1, got_en[n]);
            end
        end
    endtask

    task automatic test_diff_bank();
        clr();
        wa_d[0] = 12'd257;  wd_d[0] = 32'hAAAAAAAA; we_d[0] = 1'b1;
        wa_d[1] = 12'd50;   wd_d[1] = 32'hBBBBBBBB; we_d[1] = 1'b1;
        wa_d[2] = 12'd2048; wd_d[2] = 32'h12345678; we_d[2] = 1'b1;
        step();
        checks++;
        if ({wr_enable_out1, wr_enable_out2, wr_enable_out3, wr_enable_out4} !== 4'b1110) begin
            errors++;
            $display("FAIL diff_bank_wo: got %b%b%b%b expected 1110",
                     wr_enable_out1, wr_enable_out2, wr_enable_out3, wr_enable_out4);
        end
        clr();
        ra_d[0] = 12'd257; ra_d[1] = 12'd50; ra_d[2] = 12'd50; ra_d[3] = 12'd50;
        step();
        checks++;
        if (rd_enable1 !== 1'b1 || rd_data1 !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL diff_bank_read257: got en=%b data=%h expected 1/AAAAAAAA", rd_enable1, rd_data1);
        end
        checks++;
        if ({rd_enable2, rd_enable3, rd_enable4} !== 3'b111 || rd_data4 !== 32'hBBBBBBBB) begin
            errors++;
            $display("FAIL diff_bank_read50: got en=%b%b%b data4=%h expected 111/BBBBBBBB",
                     rd_enable2, rd_enable3, rd_enable4, rd_data4);
        end
    endtask

    task automatic test_read_conflict();
        clr();
        ra_d[0] = 12'd0; ra_d[1] = 12'd1024; ra_d[2] = 12'd257; ra_d[3] = 12'd5;
        step();
        checks++;
        if (rd_enable1 !== 1'b1 || rd_enable3 !== 1'b1 || rd_data3 !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL read_conflict_winners: got en1=%b en3=%b data3=%h expected 1/1/AAAAAAAA",
                     rd_enable1, rd_enable3, rd_data3);
        end
        checks++;
        if (rd_enable4 !== 1'b0 || rd_data4 !== 32'hBBBBBBBB) begin
            errors++;
            $display("FAIL read_conflict_loser: got en4=%b data4=%h expected 0/BBBBBBBB", rd_enable4, rd_data4);
        end
    endtask

    task automatic test_shared_addr();
        clr();
        ra_d[0] = 12'd2048; ra_d[1] = 12'd2048; ra_d[2] = 12'd257; ra_d[3] = 12'd3000;
        step();
        checks++;
        if ({rd_enable1, rd_enable2, rd_enable3} !== 3'b111) begin
            errors++;
            $display("FAIL shared_en: got %b%b%b expected 111", rd_enable1, rd_enable2, rd_enable3);
        end
        checks++;
        if (rd_data1 !== 32'h12345678 || rd_data2 !== 32'h12345678 || rd_data3 !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL shared_data: got %h %h %h expected 12345678 12345678 AAAAAAAA",
                     rd_data1, rd_data2, rd_data3);
        end
    endtask

    task automatic test_write_conflict();
        clr();
        wa_d[0] = 12'd15;  wd_d[0] = 32'h11111111; we_d[0] = 1'b1;
        wa_d[1] = 12'd15;  wd_d[1] = 32'h22222222; we_d[1] = 1'b1;
        wa_d[2] = 12'd256; wd_d[2] = 32'hDDDDDDDD; we_d[2] = 1'b1;
        step();
        checks++;
        if ({wr_enable_out1, wr_enable_out2, wr_enable_out3} !== 3'b101) begin
            errors++;
            $display("FAIL write_conflict_wo: got %b%b%b expected 101",
                     wr_enable_out1, wr_enable_out2, wr_enable_out3);
        end
        clr();
        ra_d[0] = 12'd15;
        step();
        checks++;
        if (rd_data1 !== 32'h11111111) begin
            errors++;
            $display("FAIL write_conflict_read: got %h expected 11111111", rd_data1);
        end
    endtask

    task automatic test_read_first();
        clr();
        ra_d[0] = 12'd256;
        wa_d[0] = 12'd256; wd_d[0] = 32'hCCCCCCCC; we_d[0] = 1'b1;
        step();
        checks++;
        if (rd_enable1 !== 1'b1 || rd_data1 !== 32'hDDDDDDDD) begin
            errors++;
            $display("FAIL read_first_old: got en=%b data=%h expected 1/DDDDDDDD", rd_enable1, rd_data1);
        end
        clr();
        ra_d[0] = 12'd256;
        step();
        checks++;
        if (rd_data1 !== 32'hCCCCCCCC) begin
            errors++;
            $display("FAIL read_first_new: got %h expected CCCCCCCC", rd_data1);
        end
    endtask

    task automatic test_async_reset();
        clr();
        ra_d[0] = 12'd15;
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (got_d[n] !== 32'h0 || got_en[n] !== 1'b0 || got_wo[n] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset port%0d: got data=%h en=%b wo=%b expected 0/0/0",
                         n + 1, got_d[n], got_en[n], got_wo[n]);
            end
        end
        clr();
        wa_d[0] = 12'd15; wd_d[0] = 32'h99999999; we_d[0] = 1'b1;
        step();
        reset = 1'b1;
        clr();
        ra_d[0] = 12'd15;
        step();
        checks++;
        if (rd_enable1 !== 1'b1 || rd_data1 !== 32'h11111111) begin
            errors++;
            $display("FAIL async_reset_resume: got en=%b data=%h expected 1/11111111", rd_enable1, rd_data1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 4; n++) begin
                ra_d[n] = 12'($urandom_range(0, 3) * 256 + $urandom_range(0, 7));
                wa_d[n] = 12'($urandom_range(0, 3) * 256 + $urandom_range(0, 7));
                wd_d[n] = $urandom;
                we_d[n] = ($urandom_range(0, 2) == 0);
            end
            step();
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (got_en[n] !== exp_en[n] || got_wo[n] !== exp_wo[n] ||
                    (exp_k[n] && got_d[n] !== exp_d[n])) begin
                    errors++;
                    $display("FAIL random cyc%0d port%0d: got en=%b wo=%b data=%h expected en=%b wo=%b data=%h(known=%b)",
                             i, n + 1, got_en[n], got_wo[n], got_d[n], exp_en[n], exp_wo[n], exp_d[n], exp_k[n]);
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem_v[a] = 1'b0;
        model_reset();
        test_reset();
        test_diff_bank();
        test_read_conflict();
        test_shared_addr();
        test_write_conflict();
        test_read_first();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_memory_controller.md
BLOCK_MEMORY_CONTROLLER -- requirements
Module: block_memory_controller

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first, as listed in REQ-002 to REQ-011.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 rd_addr1..rd_addr4  in  12 each  read address of read port N; every port requests a read every cycle.
REQ-005 wr_addr1..wr_addr4  in  12 each  write address of write port N.
REQ-006 wr_data1..wr_data4  in  32 each  write data of write port N.
REQ-007 wr_enable1..wr_enable4  in  1 each  write request of write port N.
REQ-008 rd_data1..rd_data4  out  32 each  registered read data of read port N.
REQ-009 rd_enable1..rd_enable4  out  1 each  high when rd_dataN holds data for the address sampled on the previous edge.
REQ-010 wr_enable_out1..wr_enable_out4  out  1 each  high for one cycle after write port N's write was committed.
REQ-011 Parameters (name, default, meaning): ADDR_W, 12, address width; DATA_W, 32, data width; BANK_BITS, 4, bank-select bits; NUM_PORTS, 4, ports per direction.

Function
REQ-012 Storage SHALL be 4096 x 32 words, split into 16 banks of 256 words; bank = addr[11:8], offset = addr[7:0].
REQ-013 Each bank SHALL serve at most one read and one write per cycle.
REQ-014 Read arbitration per bank SHALL use fixed priority: port 1 > 2 > 3 > 4.
REQ-015 Exception to REQ-014: read ports presenting the identical address as the winner are also served and receive the same data.
REQ-016 Granted read SHALL have 1-cycle latency: on the next edge, rd_dataN gets the memory word and rd_enableN = 1.
REQ-017 Losing read port SHALL drive rd_enableN = 0 and hold its previous rd_dataN; no retry or queuing.
REQ-018 Write arbitration per bank SHALL use fixed priority among ports with wr_enableN = 1: port 1 > 2 > 3 > 4.
REQ-019 The winning write SHALL commit on the edge; losing writes are dropped.
REQ-020 wr_enable_outN SHALL be 1 for exactly the cycle after port N's write committed, else 0.
REQ-021 Writes to different banks in one cycle SHALL all commit.
REQ-022 Same-cycle read and write to one address SHALL return the old data (read-first); new data is visible the following cycle.
REQ-023 Memory contents after power-up are unspecified; only written addresses are defined.

Reset
REQ-024 While reset = 0: all rd_dataN = 0, rd_enableN = 0, wr_enable_outN = 0, and no writes commit.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 Reset asserted mid-operation SHALL abort pending grants immediately (asynchronous).
REQ-027 Operation SHALL resume on the first rising edge after reset deasserts.

Structure
REQ-028 ADDR_W, DATA_W, BANK_BITS, NUM_PORTS and the bank/offset field positions SHALL live in a shared package block_memory_pkg.
REQ-029 One sub-module bank_ram (256 x 32, one synchronous read port, one write port, read-first) SHALL be instantiated 16 times.
REQ-030 Arbitration and output registers SHALL reside in the top module.

Verification
REQ-031 Reset: hold reset = 0 two cycles -> all outputs 0; after release with no writes, rd_enableN = 1 on the next edge.
REQ-032 Different-bank writes: port1 addr 257 = AAAAAAAA and port2 addr 50 = BBBBBBBB in the same cycle -> wr_enable_out1 and wr_enable_out2 = 1 next cycle; a later read of 257 returns AAAAAAAA.
REQ-033 Read conflict: rd_addr1 = 0, rd_addr3 = 257, rd_addr4 = 5 -> rd_enable1 = 1, rd_enable3 = 1 (data AAAAAAAA), rd_enable4 = 0 with rd_data4 held.
REQ-034 Shared address: rd_addr1 = 2048, rd_addr2 = 2048, rd_addr3 = 257 -> all three rd_enable = 1; ports 1 and 2 return equal data.
REQ-035 Write conflict: ports 1 and 2 both write addr 15 with 11111111 and 22222222 -> wr_enable_out1 = 1, wr_enable_out2 = 0; read of 15 returns 11111111.
REQ-036 Read-first: write 256 = CCCCCCCC while reading 256 in the same cycle -> old data returned; next cycle returns CCCCCCCC.
